// File: rtl/slave_out_port_if.sv
// ---------------------------------------------------------------------------
// slave_out_port_if
// Serial read-data link between the slave output port and the master input
// port.
//   tx_data      : serial data, LSB first       (slave -> master)
//   slave_valid  : bit 0 of a word is on tx_data (slave -> master)
//   master_ready : master can take a word        (master -> slave)
// ---------------------------------------------------------------------------
interface slave_out_port_if;
  logic tx_data;
  logic slave_valid;
  logic master_ready;

  modport slave (
    output tx_data,
    output slave_valid,
    input  master_ready
  );

  modport master (
    input  tx_data,
    input  slave_valid,
    output master_ready
  );
endinterface

// File: rtl/slave_out_port.sv
// ---------------------------------------------------------------------------
// slave_out_port
// Slave-side serial transmit port. Pulls parallel words from the local data
// source and shifts each one out LSB first after a slave_valid/master_ready
// handshake. One read sends burst_num+1 words.
//
// Optional feature macro: SLAVE_OUT_TIMEOUT_EN
//   When defined, the handshake wait is bounded by TIMEOUT_CYCLES. On expiry
//   the burst is dropped and the sticky o_timeout_err flag is raised.
//
// Ports:
//   i_clk            system clock, rising edge
//   i_reset          asynchronous active-low reset
//   i_start          one-cycle read request, honoured only when idle
//   i_burst_num      words in burst minus one, latched on accepted start
//   i_data_in        parallel word from the data source
//   i_data_in_valid  i_data_in holds a valid word
//   o_data_in_ready  port takes i_data_in this cycle
//   o_tx_done        one-cycle pulse after the last bit of the burst
//   o_busy           high whenever the port is not idle
//   o_timeout_err    sticky handshake timeout (SLAVE_OUT_TIMEOUT_EN only)
//   bus              serial link (tx_data, slave_valid, master_ready)
//
// state   | meaning
// --------+---------------------------------------------------------------
// IDLE    | waiting for i_start; tx_done pulse is retired here
// LOAD    | data_in_ready high, waiting for a word from the source
// WAIT_HS | slave_valid high with bit 0 on tx_data, waiting for master_ready
// SEND    | shifting bits 1..DATA_LEN-1, master_ready ignored
// ---------------------------------------------------------------------------
module slave_out_port #(
  parameter int DATA_LEN       = 8,
  parameter int BURST_LEN      = 12,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                 i_clk,
  input  logic                 i_reset,
  input  logic                 i_start,
  input  logic [BURST_LEN-1:0] i_burst_num,
  input  logic [DATA_LEN-1:0]  i_data_in,
  input  logic                 i_data_in_valid,
  output logic                 o_data_in_ready,
  output logic                 o_tx_done,
  output logic                 o_busy,
`ifdef SLAVE_OUT_TIMEOUT_EN
  output logic                 o_timeout_err,
`endif
  slave_out_port_if.slave      bus
);

  localparam int BIT_W = (DATA_LEN > 1) ? $clog2(DATA_LEN) : 1;
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(DATA_LEN - 1);

`ifdef SLAVE_OUT_TIMEOUT_EN
  localparam int TO_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [TO_W-1:0] TO_LOAD = TO_W'(TIMEOUT_CYCLES - 1);
`endif

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_LOAD    = 2'd1,
    ST_WAIT_HS = 2'd2,
    ST_SEND    = 2'd3
  } state_t;

  state_t               r_state;
  logic [DATA_LEN-1:0]  r_shift;
  logic [BIT_W-1:0]     r_bit_cnt;
  logic [BURST_LEN-1:0] r_word_cnt;
  logic [BURST_LEN-1:0] r_burst;
  logic                 r_tx_data;
  logic                 r_slave_valid;
  logic                 r_data_in_ready;
  logic                 r_tx_done;

  state_t               w_state_nxt;
  logic [DATA_LEN-1:0]  w_shift_nxt;
  logic [BIT_W-1:0]     w_bit_cnt_nxt;
  logic [BURST_LEN-1:0] w_word_cnt_nxt;
  logic [BURST_LEN-1:0] w_burst_nxt;
  logic                 w_tx_data_nxt;
  logic                 w_slave_valid_nxt;
  logic                 w_data_in_ready_nxt;
  logic                 w_tx_done_nxt;

`ifdef SLAVE_OUT_TIMEOUT_EN
  logic [TO_W-1:0]      r_to_cnt;
  logic                 r_timeout_err;
  logic [TO_W-1:0]      w_to_cnt_nxt;
  logic                 w_timeout_err_nxt;
`endif

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      r_state         <= ST_IDLE;
      r_shift         <= '0;
      r_bit_cnt       <= '0;
      r_word_cnt      <= '0;
      r_burst         <= '0;
      r_tx_data       <= 1'b0;
      r_slave_valid   <= 1'b0;
      r_data_in_ready <= 1'b0;
      r_tx_done       <= 1'b0;
`ifdef SLAVE_OUT_TIMEOUT_EN
      r_to_cnt        <= '0;
      r_timeout_err   <= 1'b0;
`endif
    end else begin
      r_state         <= w_state_nxt;
      r_shift         <= w_shift_nxt;
      r_bit_cnt       <= w_bit_cnt_nxt;
      r_word_cnt      <= w_word_cnt_nxt;
      r_burst         <= w_burst_nxt;
      r_tx_data       <= w_tx_data_nxt;
      r_slave_valid   <= w_slave_valid_nxt;
      r_data_in_ready <= w_data_in_ready_nxt;
      r_tx_done       <= w_tx_done_nxt;
`ifdef SLAVE_OUT_TIMEOUT_EN
      r_to_cnt        <= w_to_cnt_nxt;
      r_timeout_err   <= w_timeout_err_nxt;
`endif
    end
  end

  // The shift register is shifted right once per transmitted bit, so the
  // next bit to drive is always r_shift[1] and no variable index is needed.
  always_comb begin
    w_state_nxt         = r_state;
    w_shift_nxt         = r_shift;
    w_bit_cnt_nxt       = r_bit_cnt;
    w_word_cnt_nxt      = r_word_cnt;
    w_burst_nxt         = r_burst;
    w_tx_data_nxt       = r_tx_data;
    w_slave_valid_nxt   = r_slave_valid;
    w_data_in_ready_nxt = r_data_in_ready;
    w_tx_done_nxt       = 1'b0;
`ifdef SLAVE_OUT_TIMEOUT_EN
    w_to_cnt_nxt        = r_to_cnt;
    w_timeout_err_nxt   = r_timeout_err;
`endif

    case (r_state)
      ST_IDLE: begin
        if (i_start) begin
          w_burst_nxt         = i_burst_num;
          w_word_cnt_nxt      = '0;
          w_data_in_ready_nxt = 1'b1;
          w_state_nxt         = ST_LOAD;
`ifdef SLAVE_OUT_TIMEOUT_EN
          w_timeout_err_nxt   = 1'b0;
`endif
        end
      end

      ST_LOAD: begin
        if (i_data_in_valid && r_data_in_ready) begin
          w_shift_nxt         = i_data_in;
          w_tx_data_nxt       = i_data_in[0];
          w_slave_valid_nxt   = 1'b1;
          w_data_in_ready_nxt = 1'b0;
          w_state_nxt         = ST_WAIT_HS;
`ifdef SLAVE_OUT_TIMEOUT_EN
          w_to_cnt_nxt        = TO_LOAD;
`endif
        end
      end

      ST_WAIT_HS: begin
        // A handshake on the expiry edge still wins over the timeout.
        if (bus.master_ready) begin
          w_slave_valid_nxt = 1'b0;
          w_tx_data_nxt     = r_shift[1];
          w_shift_nxt       = r_shift >> 1;
          w_bit_cnt_nxt     = BIT_W'(1);
          w_state_nxt       = ST_SEND;
        end
`ifdef SLAVE_OUT_TIMEOUT_EN
        else if (r_to_cnt == '0) begin
          w_slave_valid_nxt = 1'b0;
          w_tx_data_nxt     = 1'b0;
          w_timeout_err_nxt = 1'b1;
          w_state_nxt       = ST_IDLE;
        end else begin
          w_to_cnt_nxt = r_to_cnt - 1'b1;
        end
`endif
      end

      ST_SEND: begin
        if (r_bit_cnt == BIT_LAST) begin
          w_bit_cnt_nxt = '0;
          w_tx_data_nxt = 1'b0;
          // Compare before incrementing so an all-ones burst_num never wraps.
          if (r_word_cnt == r_burst) begin
            w_tx_done_nxt = 1'b1;
            w_state_nxt   = ST_IDLE;
          end else begin
            w_word_cnt_nxt      = r_word_cnt + 1'b1;
            w_data_in_ready_nxt = 1'b1;
            w_state_nxt         = ST_LOAD;
          end
        end else begin
          w_tx_data_nxt = r_shift[1];
          w_shift_nxt   = r_shift >> 1;
          w_bit_cnt_nxt = r_bit_cnt + 1'b1;
        end
      end

      default: w_state_nxt = ST_IDLE;
    endcase
  end

  assign bus.tx_data     = r_tx_data;
  assign bus.slave_valid = r_slave_valid;
  assign o_data_in_ready = r_data_in_ready;
  assign o_tx_done       = r_tx_done;
  assign o_busy          = (r_state != ST_IDLE);
`ifdef SLAVE_OUT_TIMEOUT_EN
  assign o_timeout_err   = r_timeout_err;
`endif

endmodule

// File: doc/slave_out_port.md
Name: slave_out_port

Overview:
- Serial transmit port on the slave side of the bus. It produces the read-data stream consumed by the master input port.
- Pulls parallel words from the slave's local data source and serializes them LSB first on tx_data.
- Each word is framed by a slave_valid/master_ready handshake. A burst of burst_num+1 words is sent per read.

Parameters:
DATA_LEN, 8, bits per word; also the number of serial cycles per word
BURST_LEN, 12, width of burst_num and of the internal word counter
TIMEOUT_CYCLES, 255, handshake wait limit (used only when SLAVE_OUT_TIMEOUT_EN is defined)

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-low reset
start  input  1  one-cycle request to begin a read burst; sampled only in IDLE
burst_num  input  BURST_LEN  burst length minus one; latched when start is accepted
data_in  input  DATA_LEN  parallel word from the slave data source
data_in_valid  input  1  data_in holds a valid word
data_in_ready  output  1  port accepts data_in this cycle
tx_data  output  1  serial data line to the master
slave_valid  output  1  first bit of a word is present on tx_data
master_ready  input  1  master ready to receive
tx_done  output  1  one-cycle pulse after the last bit of the burst
busy  output  1  high in any state other than IDLE
timeout_err  output  1  sticky error flag; exists only with SLAVE_OUT_TIMEOUT_EN

Behaviour:
- Reset (reset=0, asynchronous):
  - state=IDLE.
  - tx_data=0, slave_valid=0, data_in_ready=0, tx_done=0, timeout_err=0.
  - Shift register, bit counter and word counter cleared.
  - A reset mid-burst aborts the burst with no tx_done.
- All outputs are registered. busy is decoded from state.
- IDLE:
  - tx_done is cleared to 0 here.
  - On start=1: latch burst_num into burst_reg, set word_cnt=0, go to LOAD.
  - start in any other state is ignored.
- LOAD:
  - data_in_ready=1.
  - On data_in_valid & data_in_ready: shift_reg<=data_in, tx_data<=data_in[0], slave_valid<=1, data_in_ready<=0, go to WAIT_HS.
  - With no valid word, stay in LOAD indefinitely.
- WAIT_HS:
  - Hold slave_valid=1 and tx_data=shift_reg[0].
  - On the first edge with master_ready=1 (handshake edge E0, where the master samples bit 0): slave_valid<=0, tx_data<=shift_reg[1], bit_cnt<=1, go to SEND.
- SEND:
  - tx_data carries bit k during the cycle between edges E(k-1) and E(k).
  - At each edge with bit_cnt<DATA_LEN-1: tx_data<=shift_reg[bit_cnt+1], bit_cnt<=bit_cnt+1.
  - At edge E(DATA_LEN-1), with bit_cnt==DATA_LEN-1:
    - bit_cnt<=0.
    - If word_cnt==burst_reg: tx_done<=1, go to IDLE.
    - Otherwise: word_cnt<=word_cnt+1, go to LOAD.
  - master_ready is ignored during SEND.
- Word timing: exactly DATA_LEN consecutive bit cycles after the handshake, with no gaps.
- Gaps between words are at least 2 cycles (LOAD, then WAIT_HS).
- word_cnt is compared before it is incremented, so burst_num all-ones gives 2^BURST_LEN words with no overflow.
- System constraint: the bus controller asserts start only after the master port has entered its handshake-wait state. While idle, master_ready=1 is not a valid handshake.
- Simultaneous data_in_valid and start in IDLE: start is taken; the word is accepted in the next cycle, in LOAD.

Optional Feature:
- Macro SLAVE_OUT_TIMEOUT_EN, when defined:
  - A counter runs while in WAIT_HS.
  - If it reaches TIMEOUT_CYCLES without a handshake: slave_valid<=0, timeout_err<=1, go to IDLE with no tx_done.
  - timeout_err stays set until reset or the next accepted start.
- When undefined: no counter, no timeout_err port, and WAIT_HS waits forever.

Test Plan:
- Single word: start with burst_num=0, data_in=0xA5 valid, master_ready=1 in WAIT_HS -> tx_data on edges E0..E7 = 1,0,1,0,0,1,0,1. slave_valid high only up to E0. tx_done high for exactly one cycle after E7. busy=0 afterwards.
- Burst: burst_num=2, words 0x01, 0x80, 0xFF -> three handshakes, serial LSB-first streams matching each word, tx_done once after the third word only.
- Handshake stall: master_ready=0 for 10 cycles in WAIT_HS -> slave_valid and tx_data=bit0 held stable. Serialization starts at the first edge with master_ready=1.
- Source stall: data_in_valid low for 5 cycles in LOAD -> data_in_ready stays 1 and slave_valid stays 0. Transmission proceeds once valid is asserted.
- Reset mid-word: reset=0 at bit 4 of 0x3C -> all outputs return to 0 immediately, no tx_done. A new start afterwards works normally.
- Timeout (with SLAVE_OUT_TIMEOUT_EN, TIMEOUT_CYCLES=16): master_ready held 0 -> after 16 cycles slave_valid=0, timeout_err=1, state IDLE, no tx_done.
